// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared state encoding and default constants for the fetch stage
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

    localparam logic [15:0] FETCH_RESET_PC  = 16'h0000;
    localparam logic [15:0] FETCH_NOP_INSTR = 16'h0800;
    localparam logic [4:0]  FETCH_HALT_OPC  = 5'b00000;

endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: pc register, next-pc mux (redirect / hold buffer / base+2) and the +2 adder
module fetch_pc_unit
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] target,
    input  logic        adv,
    input  logic        sel_hold,
    input  logic [15:0] hold_val,
    input  logic [15:0] base,
    output logic [15:0] pc,
    output logic [15:0] inc
);

    logic [15:0] next;

    assign inc  = base + 16'd2;
    assign next = redirect ? target : sel_hold ? hold_val : inc;

    register #(.W(16), .RV(RESET_PC)) u_pc (
        .clk(clk),
        .rst(rst),
        .en (redirect | adv),
        .d  (next),
        .q  (pc)
    );

endmodule

// File: rtl/register.sv
// register: enable-gated register with asynchronous active-low reset to a parameterised value
module register #(
    parameter int           W  = 16,
    parameter logic [W-1:0] RV = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // load d when enabled, return to RV on reset
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= RV;
        else if (en)
            q <= d;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with variable-latency memory, redirect, stall and HALT handling
// Optional macro FETCH_ALIGN_CHK_EN: odd redirect targets raise a sticky err and halt fetch.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [15:0] NOP_INSTR = FETCH_NOP_INSTR,
    parameter logic [4:0]  HALT_OPC  = FETCH_HALT_OPC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        imem_err,
    output logic [15:0] out_instr,
    output logic [15:0] out_PC_inc,
    output logic        out_stall_n,
    output logic        halted,
    output logic        err
);

    fetch_state_t state;
    logic        live, squash, err_q;
    logic        st_run, st_wait, st_hold, bad_align;
    logic        run_dlv, wait_dlv, hold_dlv, deliver, is_halt, x_in;
    logic [15:0] pc, inc, req_addr, hold_instr, hold_pcinc, target, cur_instr;

    assign st_run  = state == RUN;
    assign st_wait = state == WAIT;
    assign st_hold = state == HOLD;

`ifdef FETCH_ALIGN_CHK_EN
    assign target    = redirect_pc;
    assign bad_align = redirect & redirect_pc[0];
`else
    assign target    = {redirect_pc[15:1], 1'b0};
    assign bad_align = 1'b0;
`endif

    // live keeps the first post-reset cycle request-free; WAIT must hold its request even under redirect
    assign imem_rd   = st_wait | (st_run & live & ~redirect & ~hz_stall);
    assign imem_addr = st_wait ? req_addr : pc;

    assign run_dlv   = st_run & imem_rd & imem_done;
    assign wait_dlv  = st_wait & imem_done & ~squash & ~redirect & ~hz_stall;
    assign hold_dlv  = st_hold & ~redirect & ~hz_stall;
    assign deliver   = run_dlv | wait_dlv | hold_dlv;
    assign cur_instr = st_hold ? hold_instr : imem_data;
    assign is_halt   = cur_instr[15:11] == HALT_OPC;

    assign out_stall_n = deliver;
    assign out_instr   = deliver ? cur_instr : NOP_INSTR;
    assign out_PC_inc  = deliver ? (st_hold ? hold_pcinc : inc) : 16'h0000;
    assign halted      = state == HALT;

    assign x_in = $isunknown({hz_stall, redirect, redirect_pc, imem_data, imem_done, imem_err});
    assign err  = imem_err | (rst & x_in) | err_q;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
        .clk     (clk),
        .rst     (rst),
        .redirect(redirect),
        .target  (target),
        .adv     (deliver),
        .sel_hold(st_hold),
        .hold_val(hold_pcinc),
        .base    (imem_addr),
        .pc      (pc),
        .inc     (inc)
    );

    register #(.W(16)) u_req (
        .clk(clk),
        .rst(rst),
        .en (st_run & imem_rd & ~imem_done),
        .d  (pc),
        .q  (req_addr)
    );

    register #(.W(32)) u_hold (
        .clk(clk),
        .rst(rst),
        .en (st_wait & imem_done & ~squash & ~redirect & hz_stall),
        .d  ({imem_data, inc}),
        .q  ({hold_instr, hold_pcinc})
    );

    // fetch control: redirect first, then per-state progress and HALT detection
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= RUN;
            live   <= 1'b0;
            squash <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (redirect) begin
                if (bad_align) begin
                    state <= HALT;
                    err_q <= 1'b1;
                end else if (st_wait && !imem_done) begin
                    squash <= 1'b1;
                end else begin
                    state  <= RUN;
                    squash <= 1'b0;
                end
            end else begin
                case (state)
                    RUN:  if (run_dlv) state <= is_halt ? HALT : RUN;
                          else if (imem_rd) state <= WAIT;
                    WAIT: if (imem_done) begin
                              squash <= 1'b0;
                              state  <= squash ? RUN : hz_stall ? HOLD : is_halt ? HALT : RUN;
                          end
                    HOLD: if (!hz_stall) state <= is_halt ? HALT : RUN;
                    HALT: state <= HALT;
                endcase
            end
        end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed check of fetch_stage plus async reset and alignment sequences
module tb_fetch_stage;

    logic        clk, rst, hz_stall, redirect, imem_done, imem_err;
    logic [15:0] redirect_pc, imem_data;
    logic        imem_rd, out_stall_n, halted, err;
    logic [15:0] imem_addr, out_instr, out_PC_inc;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        hz, rdr;
        logic [15:0] rpc;
        logic        done;
        logic [15:0] data;
        logic        ierr;
        logic        rd;
        logic [15:0] addr;
        logic        sn;
        logic [15:0] instr, pcinc;
        logic        halt, er;
    } vec_t;

    vec_t tbl[$];

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .hz_stall   (hz_stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_rd    (imem_rd),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_done  (imem_done),
        .imem_err   (imem_err),
        .out_instr  (out_instr),
        .out_PC_inc (out_PC_inc),
        .out_stall_n(out_stall_n),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic vec_t mk(logic hz, logic rdr, logic [15:0] rpc, logic done, logic [15:0] data,
                                logic ierr, logic rd, logic [15:0] addr, logic sn, logic [15:0] instr,
                                logic [15:0] pcinc, logic halt, logic er);
        vec_t v;
        v.hz = hz; v.rdr = rdr; v.rpc = rpc; v.done = done; v.data = data; v.ierr = ierr;
        v.rd = rd; v.addr = addr; v.sn = sn; v.instr = instr; v.pcinc = pcinc; v.halt = halt; v.er = er;
        return v;
    endfunction

    function automatic logic [51:0] outs();
        return {imem_rd, imem_addr, out_stall_n, out_instr, out_PC_inc, halted, err};
    endfunction

    task automatic chk(input string nm, input logic [51:0] act, input logic [51:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic hz, input logic rdr, input logic [15:0] rpc, input logic done,
                         input logic [15:0] data, input logic ierr);
        hz_stall = hz; redirect = rdr; redirect_pc = rpc;
        imem_done = done; imem_data = data; imem_err = ierr;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 16'h0, 0, 16'h0, 0);
        //        hz rdr rpc       done data      ie | rd addr     sn instr     pcinc     h e
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h4001, 0, 1, 16'h0000, 1, 16'h4001, 16'h0002, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h4002, 0, 1, 16'h0002, 1, 16'h4002, 16'h0004, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0100, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h5555, 0, 1, 16'h0004, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0100, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 1, 16'h1234, 0, 1, 16'h0100, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0100, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0100, 1, 16'h1234, 16'h0102, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0102, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h1111, 0, 1, 16'h0102, 1, 16'h1111, 16'h0104, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0006, 0, 16'h0000, 0, 0, 16'h0104, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 0, 1, 16'h0006, 1, 16'h0000, 16'h0008, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0008, 0, 16'h0800, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h7777, 0, 0, 16'h0008, 0, 16'h0800, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 1, 16'h0020, 0, 16'h0000, 0, 0, 16'h0008, 0, 16'h0800, 16'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h2222, 0, 1, 16'h0020, 1, 16'h2222, 16'h0022, 0, 0));
        tbl.push_back(mk(0, 1, 16'hFFFE, 0, 16'h0000, 0, 0, 16'h0022, 0, 16'h0800, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h3333, 0, 1, 16'hFFFE, 1, 16'h3333, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h3334, 0, 1, 16'h0000, 1, 16'h3334, 16'h0002, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h0800, 16'h0000, 0, 1));

        repeat (2) @(negedge clk);
        chk("reset_state", outs(), {1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0});
        rst = 1'b1;
        #2 chk("rd_low_after_release", 52'(imem_rd), 52'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].hz, tbl[i].rdr, tbl[i].rpc, tbl[i].done, tbl[i].data, tbl[i].ierr);
            #2 chk($sformatf("vec%0d", i), outs(),
                   {tbl[i].rd, tbl[i].addr, tbl[i].sn, tbl[i].instr, tbl[i].pcinc, tbl[i].halt, tbl[i].er});
        end

        @(negedge clk);
        drive(0, 0, 16'h0, 0, 16'h0, 0);
        #2 chk("wait_before_reset", {35'd0, imem_rd, imem_addr}, {35'd0, 1'b1, 16'h0002});
        #1 rst = 1'b0;
        #1 chk("async_reset_rd", {50'd0, imem_rd, out_stall_n}, 52'd0);
        #1 rst = 1'b1;
        #1 chk("rd_low_after_rerelease", 52'(imem_rd), 52'd0);

        @(negedge clk);
        drive(0, 0, 16'h0, 1, 16'h4444, 0);
        #2 chk("pc_is_reset_pc", outs(), {1'b1, 16'h0000, 1'b1, 16'h4444, 16'h0002, 1'b0, 1'b0});

        @(negedge clk);
        drive(0, 1, 16'h0011, 0, 16'h0, 0);
        #2 chk("odd_redirect_bubble", {50'd0, imem_rd, out_stall_n}, 52'd0);

        @(negedge clk);
        drive(0, 0, 16'h0, 0, 16'h0, 0);
`ifdef FETCH_ALIGN_CHK_EN
        #2 chk("align_err_halt", {49'd0, imem_rd, halted, err}, {49'd0, 1'b0, 1'b1, 1'b1});
`else
        #2 chk("align_forced_even", {33'd0, imem_rd, imem_addr, halted, err}, {33'd0, 1'b1, 16'h0010, 1'b0, 1'b0});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage 16-bit pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word requests to a variable-latency instruction memory.
- Applies decode-stage redirects and hazard stalls, and stops fetching on HALT.
- Drives IF/ID with instruction, PC+2 and an active-low stall_n, where stall_n=1 means a valid instruction is being written.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, instruction driven on bubble cycles
- HALT_OPC, 5'b00000, opcode in instr[15:11] that stops fetch

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- hz_stall  input  1  decode hazard; no new instruction may be handed to IF/ID
- redirect  input  1  taken branch/jump resolved in decode
- redirect_pc  input  16  target PC for redirect
- imem_rd  output  1  memory read request, held until imem_done
- imem_addr  output  16  request address, stable while imem_rd=1
- imem_data  input  16  returned instruction, valid when imem_done=1
- imem_done  input  1  request complete; may assert in the same cycle as imem_rd
- imem_err  input  1  memory error
- out_instr  output  16  instruction to IF/ID
- out_PC_inc  output  16  address of out_instr plus 2, to IF/ID
- out_stall_n  output  1  1 = out_instr/out_PC_inc valid, IF/ID writes them
- halted  output  1  fetch stopped on HALT
- err  output  1  error flag

Behaviour:
- States: RUN, WAIT, HOLD, HALT. Registers: pc, req_addr, squash, hold_instr, hold_pcinc.
- Reset (rst=0, async):
  - state=RUN, pc=RESET_PC, squash=0.
  - Outputs: imem_rd=0, out_stall_n=0, out_instr=NOP_INSTR, out_PC_inc=0, halted=0, err=0.
  - imem_rd stays 0 until the first clock edge after rst deasserts.
- Bubble rule: whenever out_stall_n=0, out_instr=NOP_INSTR. All out_* outputs are combinational from the state and registers.
- RUN:
  - If hz_stall=0 and redirect=0: imem_rd=1, imem_addr=pc.
  - If imem_done in the same cycle: out_stall_n=1, out_instr=imem_data, out_PC_inc=pc+2, pc<=pc+2.
  - If imem_done=0: req_addr<=pc, go to WAIT.
  - If hz_stall=1: imem_rd=0, pc held.
- WAIT:
  - imem_rd=1, imem_addr=req_addr. The memory cannot abort a request, so the address stays stable until done.
  - On imem_done with squash=1: discard data, clear squash, go to RUN.
  - On imem_done with squash=0 and hz_stall=0: output the instruction (out_PC_inc=req_addr+2), pc<=req_addr+2, go to RUN.
  - On imem_done with squash=0 and hz_stall=1: capture into hold_instr/hold_pcinc, go to HOLD.
- HOLD:
  - imem_rd=0.
  - When hz_stall=0: out_stall_n=1, out_instr=hold_instr, out_PC_inc=hold_pcinc, pc<=hold_pcinc, go to RUN.
- HALT detection: any instruction delivered with instr[15:11]==HALT_OPC is still passed to IF/ID with out_stall_n=1, then state goes to HALT. In HALT: imem_rd=0, halted=1.
- Redirect (highest priority, any state):
  - out_stall_n=0 that cycle; pc<=redirect_pc.
  - RUN: no request is issued that cycle.
  - WAIT: squash<=1 and the stage stays in WAIT. If imem_done arrives in the same cycle as redirect, the data is discarded and the stage goes to RUN.
  - HOLD: hold buffer dropped, go to RUN.
  - HALT: halted cleared, go to RUN (the HALT was fetched on the wrong path).
- Redirect with hz_stall=1: redirect wins; pc updates and a bubble is produced.
- Arithmetic: PC+2 wraps modulo 2^16 (16'hFFFE+2 = 16'h0000).
- Errors: err=imem_err | (rst==1 and any input is X), combinational. err has no effect on state.

Optional Feature:
- Macro: FETCH_ALIGN_CHK_EN.
- Defined: a redirect with redirect_pc[0]=1 asserts err (registered, sticky until reset) and sends the stage to HALT with halted=1; no request is issued.
- Undefined: redirect_pc[0] is forced to 0 and err is driven only by imem_err and X detection.

Decomposition:
- Shared package holds:
  - the state encoding typedef (RUN/WAIT/HOLD/HALT);
  - the NOP_INSTR and HALT_OPC constants;
  - the RESET_PC default.
- One natural sub-module: fetch_pc_unit, which holds the pc register, the next-PC mux (pc+2 / redirect_pc / hold) and the +2 adder.
- Instantiate the existing `register` module for pc, req_addr and the hold buffer.

Test Plan:
- Reset release, memory done same-cycle returning 16'h4001, 16'h4002: out_stall_n=1 on consecutive cycles; out_PC_inc=16'h0002, then 16'h0004; imem_addr 0, 2, 4.
- imem_done delayed 3 cycles, redirect to 16'h0100 on the 2nd wait cycle: imem_addr stays at the old value until done, data discarded, out_stall_n=0, next imem_addr=16'h0100.
- hz_stall high when a delayed done returns 16'h1234: no write to IF/ID; once hz_stall drops, out_instr=16'h1234 for exactly 1 cycle with out_stall_n=1.
- Fetch 16'h0000 (HALT) at PC 16'h0006: delivered once with out_PC_inc=16'h0008; then halted=1 and imem_rd=0 indefinitely; a later redirect to 16'h0020 resumes fetch.
- PC at 16'hFFFE: out_PC_inc=16'h0000 and next imem_addr=16'h0000. rst pulsed low mid-WAIT: imem_rd drops asynchronously; after release pc=RESET_PC.
- With FETCH_ALIGN_CHK_EN, redirect to 16'h0011: err=1 and halted=1. Without the macro: imem_addr=16'h0010 and err=0.
